mask_len_acc: RTL and testbench
===============================

# mask_len_acc

Sequential inverse of the length-to-mask converter. Consumes a beat stream in which each beat carries a thermometer byte-valid mask, decodes each mask back to a byte count, and accumulates a per-packet length. At packet end it emits one length descriptor with error flags on a valid/ready output. It sits on the receive side of the datapath, ahead of length-checking and framing logic.

## Interface
- MASK_W, 8, bytes per beat (mask width, ≥2)
- BEAT_LEN_W, 4, width of decoded beat length, = $clog2(MASK_W)+1
- PKT_LEN_W, 16, width of accumulated packet length
- clk  in  1  clock
- nreset  in  1  reset, asynchronous, active-low
- valid_i  in  1  input beat valid
- mask_i  in  MASK_W  thermometer byte-valid mask, bit 0 = first byte
- last_i  in  1  final beat of packet
- ready_o  out  1  input beat accepted when valid_i & ready_o
- len_valid_o  out  1  descriptor valid
- len_o  out  PKT_LEN_W  packet length in bytes
- len_err_o  out  2  error flags: bit 0 MALFORMED, bit 1 OVERFLOW
- len_ready_i  in  1  descriptor consumed when len_valid_o & len_ready_i

## Operation
- Beat decode (combinational):
  - A mask is legal iff it is nonzero and mask+1 is a power of two.
  - Legal mask: beat length = popcount(mask), range 1..MASK_W.
  - Illegal mask: beat length = 0; sets MALFORMED.
- A non-last beat whose mask is legal but not all-ones contributes its length and sets MALFORMED.
- Accumulator acc (PKT_LEN_W bits) plus sticky error register err (2 bits).
- Accepted non-last beat:
  - acc ← sat(acc + beat_len)
  - err |= beat errors
- Accepted last beat:
  - len_o ← sat(acc + beat_len)
  - len_err_o ← err | beat errors
  - len_valid_o ← 1
  - acc ← 0, err ← 0
- Saturation: when a sum exceeds 2^PKT_LEN_W−1, the result clamps to 2^PKT_LEN_W−1 and OVERFLOW is set. OVERFLOW stays sticky until the packet ends.
- Two-state FSM:
  - ACC: accumulating; len_valid_o = 0.
  - HOLD: descriptor pending; len_valid_o = 1.
  - ACC→HOLD on an accepted last beat.
  - HOLD→ACC on handshake, unless a last beat is accepted in the same cycle; then stay in HOLD with the new descriptor.
- ready_o = ~len_valid_o | len_ready_i (combinational). In HOLD with len_ready_i low, no beats are accepted, including non-last beats.
- valid_i low: no state change.

## Timing
- Reset values: len_valid_o=0, len_o=0, len_err_o=0, acc=0, err=0, state ACC. ready_o=1 out of reset.
- Latency: descriptor is valid the cycle after its last beat is accepted.
- Throughput: one beat per cycle. Single-beat packets can complete back-to-back, one descriptor per cycle, while len_ready_i=1.
- Descriptor outputs are held stable while len_valid_o & ~len_ready_i.
- Reset mid-packet: partial acc/err discarded; no descriptor is emitted for that packet.
- Reset while in HOLD: descriptor dropped.
- mask_i and last_i are ignored when valid_i=0.

## Structure
- Package mask_len_pkg:
  - ERR_MALFORMED = 0, ERR_OVERFLOW = 1 bit indices
  - 2-bit len_err_t typedef
  - FSM state enum {ACC, HOLD}
- Sub-module mask_to_len: combinational. Inputs mask_i. Outputs len_o [BEAT_LEN_W-1:0] and legal_o. Instantiated once.
- Top holds the FSM, accumulator, saturating adder and output registers.
- Formal properties under FORMAL:
  - len_o ≤ saturation maximum
  - descriptor outputs stable under backpressure
  - ready_o matches its equation

## Test plan
- MASK_W=8. Single beat, mask 8'h07, last=1 → next cycle len_valid_o=1, len_o=3, len_err_o=2'b00.
- Beats 8'hFF, 8'hFF, 8'h1F (last) → len_o=21, len_err_o=0, one descriptor only.
- Beats 8'hFF, 8'h05 (last) → len_o=8, len_err_o=2'b01. Beats 8'h0F, 8'hFF (last) → len_o=12, len_err_o=2'b01.
- PKT_LEN_W=4. Beats 8'hFF, 8'hFF, 8'hFF (last) → len_o=15, len_err_o=2'b10. The following clean 8'h01 packet → len_o=1, err=0 (sticky cleared).
- Backpressure:
  - Hold len_ready_i=0 after a descriptor → ready_o=0 and outputs stable for 5 cycles.
  - Raise len_ready_i in the same cycle as a last beat 8'h03 → len_valid_o stays 1 and len_o updates to 2 the next cycle.
- Assert nreset after 2 non-last 8'hFF beats, release, send 8'h01 last → len_o=1. No descriptor for the aborted packet.

Source files
------------

// File: rtl/mask_len_pkg.sv
// Shared types for the mask-to-length accumulator: error flag indices,
// the error flag vector and the descriptor FSM states.
package mask_len_pkg;

  localparam int ERR_MALFORMED = 0;
  localparam int ERR_OVERFLOW  = 1;

  typedef logic [1:0] len_err_t;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/mask_to_len.sv
// Decodes one thermometer byte-valid mask into a byte count; illegal masks
// (zero, or holes in the thermometer) decode to length 0.
module mask_to_len #(
  parameter int MASK_W     = 8,
  parameter int BEAT_LEN_W = $clog2(MASK_W) + 1
) (
  input  logic [MASK_W-1:0]     mask_i,
  output logic [BEAT_LEN_W-1:0] len_o,
  output logic                  legal_o
);

  logic [MASK_W:0]       w_plus1;
  logic                  w_pow2;
  logic [BEAT_LEN_W-1:0] w_count;

  // A thermometer mask plus one is a single set bit; all-ones needs the extra bit.
  assign w_plus1 = {1'b0, mask_i} + (MASK_W + 1)'(1);
  assign w_pow2  = ((w_plus1 & (w_plus1 - (MASK_W + 1)'(1))) == '0);
  assign legal_o = (|mask_i) & w_pow2;

  always_comb begin
    w_count = '0;
    for (int i = 0; i < MASK_W; i++) begin
      w_count = w_count + BEAT_LEN_W'(mask_i[i]);
    end
  end

  assign len_o = legal_o ? w_count : '0;

endmodule

// File: rtl/mask_len_acc.sv
// Accumulates decoded beat lengths into a saturating per-packet length and
// presents one length descriptor with sticky error flags per packet.
module mask_len_acc
  import mask_len_pkg::*;
#(
  parameter int MASK_W     = 8,
  parameter int BEAT_LEN_W = $clog2(MASK_W) + 1,
  parameter int PKT_LEN_W  = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 valid_i,
  input  logic [MASK_W-1:0]    mask_i,
  input  logic                 last_i,
  output logic                 ready_o,
  output logic                 len_valid_o,
  output logic [PKT_LEN_W-1:0] len_o,
  output len_err_t             len_err_o,
  input  logic                 len_ready_i
);

  logic [BEAT_LEN_W-1:0] w_beat_len;
  logic                  w_legal;
  logic                  w_accept;
  logic [PKT_LEN_W:0]    w_sum;
  logic [PKT_LEN_W-1:0]  w_sat;
  len_err_t              w_beat_err;
  state_t                r_state;
  state_t                w_next_state;
  logic [PKT_LEN_W-1:0]  r_acc;
  len_err_t              r_err;
  logic [PKT_LEN_W-1:0]  r_len;
  len_err_t              r_len_err;

  mask_to_len #(
    .MASK_W     (MASK_W),
    .BEAT_LEN_W (BEAT_LEN_W)
  ) u_mask_to_len (
    .mask_i  (mask_i),
    .len_o   (w_beat_len),
    .legal_o (w_legal)
  );

  assign len_valid_o = (r_state == HOLD);
  assign ready_o     = ~len_valid_o | len_ready_i;
  assign w_accept    = valid_i & ready_o;
  assign len_o       = r_len;
  assign len_err_o   = r_len_err;

  // Carry out of the widened sum marks saturation.
  assign w_sum = {1'b0, r_acc} + (PKT_LEN_W + 1)'(w_beat_len);
  assign w_sat = w_sum[PKT_LEN_W] ? '1 : w_sum[PKT_LEN_W-1:0];

  always_comb begin
    w_beat_err                = '0;
    w_beat_err[ERR_MALFORMED] = ~w_legal | (~last_i & ~(&mask_i));
    w_beat_err[ERR_OVERFLOW]  = w_sum[PKT_LEN_W];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= ACC;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ACC:  if (w_accept && last_i) w_next_state = HOLD;
      HOLD: if (w_accept && last_i) w_next_state = HOLD;
            else if (len_ready_i)   w_next_state = ACC;
      default: w_next_state = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_acc     <= '0;
      r_err     <= '0;
      r_len     <= '0;
      r_len_err <= '0;
    end else if (w_accept) begin
      if (last_i) begin
        r_len     <= w_sat;
        r_len_err <= r_err | w_beat_err;
        r_acc     <= '0;
        r_err     <= '0;
      end else begin
        r_acc <= w_sat;
        r_err <= r_err | w_beat_err;
      end
    end
  end

`ifdef FORMAL
  a_len_max: assert property (@(posedge clk) disable iff (!nreset)
    len_o <= {PKT_LEN_W{1'b1}});
  a_stable: assert property (@(posedge clk) disable iff (!nreset)
    (len_valid_o && !len_ready_i) |=> (len_valid_o && $stable(len_o) && $stable(len_err_o)));
  a_ready: assert property (@(posedge clk) disable iff (!nreset)
    ready_o == (~len_valid_o | len_ready_i));
`endif

endmodule

// File: tb/tb_mask_len_acc.sv
// Drives a shared beat stream into a 16-bit and a 4-bit length instance and
// scoreboards the descriptors both produce against hand-derived values.
module tb_mask_len_acc;

  typedef struct {
    logic [15:0] len16;
    logic [1:0]  err16;
    logic [3:0]  len4;
    logic [1:0]  err4;
  } descExp_t;

  typedef struct {
    logic [7:0] mask;
    logic       last;
    descExp_t   exp;
  } vec_t;

  logic        clk;
  logic        nreset;
  logic        beatValid;
  logic [7:0]  beatMask;
  logic        beatLast;
  logic        lenReady;
  logic        ready16, ready4;
  logic        lenValid16, lenValid4;
  logic [15:0] len16;
  logic [3:0]  len4;
  logic [1:0]  err16, err4;

  int          checks = 0;
  int          errors = 0;
  bit          mHold = 0;
  bit          willAccept = 0;
  bit          expReady;
  descExp_t    curExp;
  descExp_t    sb[$];
  vec_t        vecs[$];

  mask_len_acc #(.MASK_W(8), .BEAT_LEN_W(4), .PKT_LEN_W(16)) dut16 (
    .clk(clk), .nreset(nreset), .valid_i(beatValid), .mask_i(beatMask),
    .last_i(beatLast), .ready_o(ready16), .len_valid_o(lenValid16),
    .len_o(len16), .len_err_o(err16), .len_ready_i(lenReady)
  );

  mask_len_acc #(.MASK_W(8), .BEAT_LEN_W(4), .PKT_LEN_W(4)) dut4 (
    .clk(clk), .nreset(nreset), .valid_i(beatValid), .mask_i(beatMask),
    .last_i(beatLast), .ready_o(ready4), .len_valid_o(lenValid4),
    .len_o(len4), .len_err_o(err4), .len_ready_i(lenReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: outputs sampled on the falling edge, acceptance of the
  // beat currently presented is decided from the bench's own HOLD tracking.
  always @(negedge clk) begin
    if (!nreset) begin
      mHold      = 1'b0;
      willAccept = 1'b0;
      sb.delete();
    end else begin
      expReady = !mHold || lenReady;
      checkOutput("ready16", 32'(ready16), 32'(expReady));
      checkOutput("ready4", 32'(ready4), 32'(expReady));
      checkOutput("lenValid16", 32'(lenValid16), 32'(mHold));
      checkOutput("lenValid4", 32'(lenValid4), 32'(mHold));
      if (mHold) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sbEmpty: got descriptor expected none");
        end else begin
          checkOutput("len16", 32'(len16), 32'(sb[0].len16));
          checkOutput("err16", 32'(err16), 32'(sb[0].err16));
          checkOutput("len4", 32'(len4), 32'(sb[0].len4));
          checkOutput("err4", 32'(err4), 32'(sb[0].err4));
          if (lenReady) void'(sb.pop_front());
        end
      end
      willAccept = beatValid && expReady;
      if (willAccept && beatLast) sb.push_back(curExp);
      mHold = (mHold && !lenReady) || (willAccept && beatLast);
    end
  end

  task automatic applyStimulus(input logic [7:0] m, input logic l, input logic [15:0] l16,
                               input logic [1:0] e16, input logic [3:0] l4, input logic [1:0] e4);
    beatValid    = 1'b1;
    beatMask     = m;
    beatLast     = l;
    curExp.len16 = l16;
    curExp.err16 = e16;
    curExp.len4  = l4;
    curExp.err4  = e4;
  endtask

  task automatic waitAccept();
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      if (willAccept) begin
        #1;
        return;
      end
    end
    checks++;
    errors++;
    $display("[TB] FAIL acceptTimeout: got no accept expected accept within 50 cycles");
    #1;
  endtask

  task automatic driveBeat(input logic [7:0] m, input logic l, input logic [15:0] l16,
                           input logic [1:0] e16, input logic [3:0] l4, input logic [1:0] e4);
    applyStimulus(m, l, l16, e16, l4, e4);
    waitAccept();
  endtask

  task automatic idle();
    beatValid = 1'b0;
    beatMask  = '0;
    beatLast  = 1'b0;
  endtask

  task automatic addVec(input logic [7:0] m, input logic l, input logic [15:0] l16,
                        input logic [1:0] e16, input logic [3:0] l4, input logic [1:0] e4);
    vec_t v;
    v.mask      = m;
    v.last      = l;
    v.exp.len16 = l16;
    v.exp.err16 = e16;
    v.exp.len4  = l4;
    v.exp.err4  = e4;
    vecs.push_back(v);
  endtask

  initial begin
    // Expected descriptors only matter on last beats.
    addVec(8'h07, 1, 16'd3,  2'b00, 4'd3,  2'b00);
    addVec(8'hFF, 0, 16'd0,  2'b00, 4'd0,  2'b00);
    addVec(8'hFF, 0, 16'd0,  2'b00, 4'd0,  2'b00);
    addVec(8'h1F, 1, 16'd21, 2'b00, 4'd15, 2'b10);
    addVec(8'hFF, 0, 16'd0,  2'b00, 4'd0,  2'b00);
    addVec(8'h05, 1, 16'd8,  2'b01, 4'd8,  2'b01);
    addVec(8'h0F, 0, 16'd0,  2'b00, 4'd0,  2'b00);
    addVec(8'hFF, 1, 16'd12, 2'b01, 4'd12, 2'b01);
    addVec(8'hFF, 0, 16'd0,  2'b00, 4'd0,  2'b00);
    addVec(8'hFF, 0, 16'd0,  2'b00, 4'd0,  2'b00);
    addVec(8'hFF, 1, 16'd24, 2'b00, 4'd15, 2'b10);
    addVec(8'h01, 1, 16'd1,  2'b00, 4'd1,  2'b00);
    addVec(8'h00, 1, 16'd0,  2'b01, 4'd0,  2'b01);
    addVec(8'h80, 1, 16'd0,  2'b01, 4'd0,  2'b01);
    addVec(8'h03, 1, 16'd2,  2'b00, 4'd2,  2'b00);
    addVec(8'hFF, 1, 16'd8,  2'b00, 4'd8,  2'b00);
    addVec(8'h3F, 0, 16'd0,  2'b00, 4'd0,  2'b00);
    addVec(8'h01, 1, 16'd7,  2'b01, 4'd7,  2'b01);

    nreset   = 1'b0;
    lenReady = 1'b1;
    curExp   = '{16'd0, 2'b00, 4'd0, 2'b00};
    idle();
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;
    @(negedge clk);
    checkOutput("rstLenValid", 32'(lenValid16), 32'd0);
    checkOutput("rstLen", 32'(len16), 32'd0);
    checkOutput("rstErr", 32'(err16), 32'd0);
    checkOutput("rstReady", 32'(ready16), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] table vectors");
    for (int i = 0; i < vecs.size(); i++) begin
      driveBeat(vecs[i].mask, vecs[i].last, vecs[i].exp.len16, vecs[i].exp.err16,
                vecs[i].exp.len4, vecs[i].exp.err4);
    end
    idle();
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] backpressure");
    lenReady = 1'b0;
    driveBeat(8'h07, 1, 16'd3, 2'b00, 4'd3, 2'b00);
    idle();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("bpReady", 32'(ready16), 32'd0);
    applyStimulus(8'h03, 1, 16'd2, 2'b00, 4'd2, 2'b00);
    repeat (3) @(posedge clk);
    #1 lenReady = 1'b1;
    waitAccept();
    idle();
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset mid-packet");
    driveBeat(8'hFF, 0, 16'd0, 2'b00, 4'd0, 2'b00);
    driveBeat(8'hFF, 0, 16'd0, 2'b00, 4'd0, 2'b00);
    idle();
    nreset = 1'b0;
    #1 checkOutput("midRstValid", 32'(lenValid16), 32'd0);
    @(posedge clk);
    #1 nreset = 1'b1;
    @(posedge clk);
    #1;
    driveBeat(8'h01, 1, 16'd1, 2'b00, 4'd1, 2'b00);
    idle();
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset in hold");
    lenReady = 1'b0;
    driveBeat(8'h07, 1, 16'd3, 2'b00, 4'd3, 2'b00);
    idle();
    @(posedge clk);
    #1 nreset = 1'b0;
    #1 checkOutput("holdRstValid", 32'(lenValid16), 32'd0);
    checkOutput("holdRstLen", 32'(len16), 32'd0);
    @(posedge clk);
    #1 nreset = 1'b1;
    lenReady = 1'b1;
    @(posedge clk);
    #1;
    driveBeat(8'h3F, 1, 16'd6, 2'b00, 4'd6, 2'b00);
    idle();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("sbDrained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
